// File: rtl/xor_gate.sv
// Registered XOR with a single-entry valid/ready stage and an accepted-pair counter.
// Optional registered parity of the result when XOR_GATE_PARITY_EN is defined.
module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic in_xfer;
    logic out_xfer;

    // One entry only: a new pair is taken when the slot is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            out       <= in0 ^ in1;
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (in_xfer) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

`ifdef XOR_GATE_PARITY_EN
    // Parity is computed from the operands so it lands in the same cycle as out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (in_xfer) begin
            out_parity <= ^(in0 ^ in1);
        end
    end
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Directed bench for xor_gate: three instances cover WIDTH=1, WIDTH=8 and a 2-bit counter.
module tb_xor_gate;

    logic clk;
    logic rst_n;

    logic [0:0]  a1, b1, o1;
    logic        v1, r1, ov1, or1, p1;
    logic [15:0] c1;

    logic [7:0]  a8, b8, o8;
    logic        v8, r8, ov8, or8, p8;
    logic [15:0] c8;

    logic [3:0]  a4, b4, o4;
    logic        v4, r4, ov4, or4, p4;
    logic [1:0]  c4;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_par07;

    xor_gate #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in0(a1), .in1(b1), .in_valid(v1), .in_ready(r1),
        .out(o1), .out_valid(ov1), .out_ready(or1), .out_parity(p1), .xfer_cnt(c1)
    );

    xor_gate #(.WIDTH(8), .CNT_W(16)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in0(a8), .in1(b8), .in_valid(v8), .in_ready(r8),
        .out(o8), .out_valid(ov8), .out_ready(or8), .out_parity(p8), .xfer_cnt(c8)
    );

    xor_gate #(.WIDTH(4), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in0(a4), .in1(b4), .in_valid(v4), .in_ready(r4),
        .out(o4), .out_valid(ov4), .out_ready(or4), .out_parity(p4), .xfer_cnt(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef XOR_GATE_PARITY_EN
        exp_par07 = 1'b1;
`else
        exp_par07 = 1'b0;
`endif
        rst_n = 1'b0;
        a1 = '0; b1 = '0; v1 = 1'b0; or1 = 1'b0;
        a8 = '0; b8 = '0; v8 = 1'b0; or8 = 1'b0;
        a4 = '0; b4 = '0; v4 = 1'b0; or4 = 1'b0;

        // reset state
        #2;
        chk("rst_out8", o8, 8'h00);
        chk("rst_ov8", ov8, 1'b0);
        chk("rst_par8", p8, 1'b0);
        chk("rst_cnt8", c8, 16'd0);
        chk("rst_rdy8", r8, 1'b1);
        chk("rst_ov1", ov1, 1'b0);
        chk("rst_cnt4", c4, 2'd0);
        #6 rst_n = 1'b1;

        // WIDTH=1 truth table, streaming with out_ready=1
        or1 = 1'b1;
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
        tick();
        chk("w1_00_out", o1, 1'b0);
        chk("w1_00_ov", ov1, 1'b1);
        a1 = 1'b0; b1 = 1'b1;
        tick();
        chk("w1_01_out", o1, 1'b1);
        chk("w1_01_ov", ov1, 1'b1);
        a1 = 1'b1; b1 = 1'b0;
        tick();
        chk("w1_10_out", o1, 1'b1);
        chk("w1_10_ov", ov1, 1'b1);
        a1 = 1'b1; b1 = 1'b1;
        tick();
        chk("w1_11_out", o1, 1'b0);
        chk("w1_11_ov", ov1, 1'b1);
        chk("w1_cnt", c1, 16'd4);
        v1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
        tick();
        chk("w1_drain_ov", ov1, 1'b0);
        chk("w1_drain_hold", o1, 1'b0);
        chk("w1_drain_cnt", c1, 16'd4);

        // WIDTH=8 stall: result held while out_ready=0
        or8 = 1'b0;
        v8 = 1'b1; a8 = 8'hA5; b8 = 8'h0F;
        tick();
        chk("stall_out", o8, 8'hAA);
        chk("stall_ov", ov8, 1'b1);
        chk("stall_rdy", r8, 1'b0);
        chk("stall_par", p8, 1'b0);
        a8 = 8'h12; b8 = 8'h34;
        tick();
        chk("stall_hold1", o8, 8'hAA);
        a8 = 8'hFF; b8 = 8'h01;
        tick();
        chk("stall_hold2", o8, 8'hAA);
        a8 = 8'h00; b8 = 8'h80;
        tick();
        chk("stall_hold3", o8, 8'hAA);
        chk("stall_cnt", c8, 16'd1);
        v8 = 1'b0; or8 = 1'b1;
        #1;
        chk("stall_rdy_comb", r8, 1'b1);
        tick();
        chk("stall_drain_ov", ov8, 1'b0);
        chk("stall_drain_out", o8, 8'hAA);

        // back-to-back, no bubble
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        tick();
        chk("b2b_out1", o8, 8'hFF);
        chk("b2b_ov1", ov8, 1'b1);
        chk("b2b_par1", p8, 1'b0);
        a8 = 8'h55; b8 = 8'h55;
        tick();
        chk("b2b_out2", o8, 8'h00);
        chk("b2b_ov2", ov8, 1'b1);
        chk("b2b_cnt", c8, 16'd3);

        // parity of 8'h07
        a8 = 8'h07; b8 = 8'h00;
        tick();
        chk("par_out", o8, 8'h07);
        chk("par_07", p8, exp_par07);
        v8 = 1'b0;
        tick();
        chk("par_idle_ov", ov8, 1'b0);
        chk("par_idle_hold", p8, exp_par07);

        // 2-bit counter wrap
        or4 = 1'b1; v4 = 1'b1; a4 = 4'hC; b4 = 4'h3;
        tick();
        chk("wrap_cnt1", c4, 2'd1);
        chk("wrap_out", o4, 4'hF);
        a4 = 4'h9;
        tick();
        chk("wrap_cnt2", c4, 2'd2);
        chk("wrap_out2", o4, 4'hA);
        tick();
        chk("wrap_cnt3", c4, 2'd3);
        tick();
        chk("wrap_cnt0", c4, 2'd0);
        tick();
        chk("wrap_cnt1b", c4, 2'd1);
        v4 = 1'b0;

        // asynchronous reset between edges with a result pending
        or8 = 1'b0; v8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F;
        tick();
        chk("arst_pre_ov", ov8, 1'b1);
        chk("arst_pre_out", o8, 8'h33);
        v8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", o8, 8'h00);
        chk("arst_ov", ov8, 1'b0);
        chk("arst_cnt", c8, 16'd0);
        chk("arst_par", p8, 1'b0);
        chk("arst_rdy", r8, 1'b1);
        chk("arst_cnt1", c1, 16'd0);
        chk("arst_cnt4", c4, 2'd0);
        #1 rst_n = 1'b1;

        // first edge after reset accepts input
        v8 = 1'b1; a8 = 8'h3C; b8 = 8'hC3;
        tick();
        chk("post_out", o8, 8'hFF);
        chk("post_ov", ov8, 1'b1);
        chk("post_cnt", c8, 16'd1);
        v8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
